// File: rtl/btb_if.sv
// Fetch-lookup and execute-update bundle for the branch target buffer.
// master drives PCs and resolutions; slave returns the prediction.
interface btb_if;
  logic [31:0] fetch_pc;
  logic        predictedTaken;
  logic [31:0] predicted_pc;
  logic        update_btb;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;

  modport master (
    output fetch_pc,
    output update_btb,
    output ex_pc,
    output ex_target,
    output ex_taken,
    input  predictedTaken,
    input  predicted_pc
  );

  modport slave (
    input  fetch_pc,
    input  update_btb,
    input  ex_pc,
    input  ex_target,
    input  ex_taken,
    output predictedTaken,
    output predicted_pc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Combinational lookup, clocked update, flop storage with async clear.
module branch_target_buffer #(
  parameter int ENTRIES = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  btb_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;

  logic             wr_en;
  logic [1:0]       ctr_nxt;
  logic [31:0]      tgt_nxt;

  logic             unused;

  assign unused = ^{bus.fetch_pc[1:0], bus.ex_pc[1:0]};

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_W+2];
  assign u_idx = bus.ex_pc[IDX_W+1:2];
  assign u_tag = bus.ex_pc[31:IDX_W+2];
  assign u_ctr = ctr_q[u_idx];

  // Lookup reads only registered state, so a same-cycle write is not seen.
  always_comb begin
    f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken = f_hit && ctr_q[f_idx][1];
  end

  assign bus.predictedTaken = f_taken;
  assign bus.predicted_pc   = f_taken ? target_q[f_idx]
                                      : bus.fetch_pc + 32'd4;

  // Decide the write: train on hit, allocate only on a taken miss.
  always_comb begin
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr_en   = 1'b0;
    ctr_nxt = u_ctr;
    tgt_nxt = target_q[u_idx];
    unique case (1'b1)
      bus.update_btb && u_hit && bus.ex_taken: begin
        wr_en   = 1'b1;
        ctr_nxt = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
        tgt_nxt = bus.ex_target;
      end
      bus.update_btb && u_hit && !bus.ex_taken: begin
        wr_en   = 1'b1;
        ctr_nxt = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
      end
      bus.update_btb && !u_hit && bus.ex_taken: begin
        wr_en   = 1'b1;
        ctr_nxt = 2'b10;
        tgt_nxt = bus.ex_target;
      end
      default: ;
    endcase
  end

  // Table storage; a hit rewrites its own tag, so one write path serves both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= tgt_nxt;
      ctr_q[u_idx]    <= ctr_nxt;
    end
  end
endmodule
